// File: rtl/mult_arb_pkg.sv
// Shared types and sizing helpers for the multiplier arbiter.
package mult_arb_pkg;

  localparam int DEF_WIDTH_A = 4;
  localparam int DEF_WIDTH_B = 6;
  localparam int PROD_W      = DEF_WIDTH_A + DEF_WIDTH_B;

  // Tag ids are carried at a fixed maximum width; the top keeps only the low id bits.
  localparam int TAG_ID_W = 8;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/Multiplier_piped.sv
// Unsigned pipelined multiplier: DELAY register stages, no stall, data registers not reset.
module Multiplier_piped #(
  parameter int WIDTH_A = 4,
  parameter int WIDTH_B = 6,
  parameter int DELAY   = 5
) (
  input  logic                       clk,
  input  logic [WIDTH_A-1:0]         a,
  input  logic [WIDTH_B-1:0]         b,
  output logic [WIDTH_A+WIDTH_B-1:0] p
);

  localparam int PW = WIDTH_A + WIDTH_B;

  logic [PW-1:0] stage_q [DELAY];

  always_ff @(posedge clk) begin
    stage_q[0] <= PW'(a) * PW'(b);
    for (int i = 1; i < DELAY; i++) begin
      stage_q[i] <= stage_q[i-1];
    end
  end

  assign p = stage_q[DELAY-1];

endmodule

// File: rtl/mult_arb_rsp_fifo.sv
// First-word-fall-through response FIFO with occupancy count; push and pop may coincide in any state.
module mult_arb_rsp_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | pop);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one pipelined multiplier between N_REQ requesters, with a
// lockstep id tag pipe and credit-gated issue into a response FIFO.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int WIDTH_A    = DEF_WIDTH_A,
  parameter int WIDTH_B    = DEF_WIDTH_B,
  parameter int DELAY      = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*WIDTH_A-1:0]     req_a,
  input  logic [N_REQ*WIDTH_B-1:0]     req_b,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [WIDTH_A+WIDTH_B-1:0]   rsp_data,
  output logic [id_width(N_REQ)-1:0]   rsp_id
);

  localparam int IDW = id_width(N_REQ);
  localparam int PW  = WIDTH_A + WIDTH_B;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  // Handshakes: a transfer happens on a channel in a cycle where valid and ready are both
  // high at the rising edge. req_ready is a function of req_valid, so requesters must not
  // derive req_valid from req_ready. rsp_valid never depends on rsp_ready.

  logic [IDW-1:0]     rr_ptr;
  logic [CW-1:0]      outstanding;
  logic               grant_found;
  logic [IDW-1:0]     grant_id;
  logic [IDW-1:0]     idx;
  logic               credit_ok;
  logic               issue;
  logic               pop;
  logic [WIDTH_A-1:0] a_sel;
  logic [WIDTH_B-1:0] b_sel;
  logic [PW-1:0]      mult_p;
  tag_t               tag_q [DELAY];
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [IDW+PW-1:0]  fifo_rdata;

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % N_REQ);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx;
      end
    end
  end

  assign credit_ok = (outstanding < CW'(FIFO_DEPTH));
  assign issue     = grant_found & credit_ok & ~rst;
  assign pop       = rsp_valid & rsp_ready;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = issue && (grant_id == IDW'(i));
    end
  end

  assign a_sel = req_a[int'(grant_id)*WIDTH_A +: WIDTH_A];
  assign b_sel = req_b[int'(grant_id)*WIDTH_B +: WIDTH_B];

  Multiplier_piped #(
    .WIDTH_A (WIDTH_A),
    .WIDTH_B (WIDTH_B),
    .DELAY   (DELAY)
  ) u_mult (
    .clk (clk),
    .a   (a_sel),
    .b   (b_sel),
    .p   (mult_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Only the valid bits are reset; a cleared valid masks whatever id is left behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DELAY; i++) begin
        tag_q[i].valid <= 1'b0;
      end
    end else begin
      tag_q[0].valid <= issue;
      tag_q[0].id    <= TAG_ID_W'(grant_id);
      for (int i = 1; i < DELAY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  mult_arb_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (IDW + PW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_q[DELAY-1].valid),
    .wdata ({tag_q[DELAY-1].id[IDW-1:0], mult_p}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rsp_valid          = ~fifo_empty;
  assign {rsp_id, rsp_data} = fifo_rdata;

endmodule
